// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: gathers operand A, operand B and an opcode from a byte
// stream, presents them to a combinational ALU, and hands the result byte to
// the UART transmitter. It waits for the transmitter to finish before it
// accepts the next command.
module alu_uart_ctrl #(
    parameter int NBITS   = 8,
    parameter int COD_OP  = 6,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [NBITS-1:0]  rx_data,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [NBITS-1:0]  tx_data,
    output logic [NBITS-1:0]  operando_A,
    output logic [NBITS-1:0]  operando_B,
    output logic [COD_OP-1:0] cod_operacion,
    input  logic [NBITS-1:0]  ALU_Result,
    output logic              busy,
    output logic              error,
    output logic              overrun
);

    // The counter keeps at least one bit so that TIMEOUT = 0 (timeout
    // disabled) still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] S_WAIT_A  = 3'd0;
    localparam logic [2:0] S_WAIT_B  = 3'd1;
    localparam logic [2:0] S_WAIT_OP = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_WAIT_TX = 3'd4;

    localparam logic [COD_OP-1:0] OP_ADD = COD_OP'(6'b100000);
    localparam logic [COD_OP-1:0] OP_SUB = COD_OP'(6'b100010);
    localparam logic [COD_OP-1:0] OP_AND = COD_OP'(6'b100100);
    localparam logic [COD_OP-1:0] OP_OR  = COD_OP'(6'b100101);
    localparam logic [COD_OP-1:0] OP_XOR = COD_OP'(6'b100110);
    localparam logic [COD_OP-1:0] OP_NOR = COD_OP'(6'b100111);
    localparam logic [COD_OP-1:0] OP_SRA = COD_OP'(6'b000011);
    localparam logic [COD_OP-1:0] OP_SRL = COD_OP'(6'b000010);

    logic [2:0]        state_q, state_d;
    logic [NBITS-1:0]  opa_q, opa_d;
    logic [NBITS-1:0]  opb_q, opb_d;
    logic [COD_OP-1:0] cod_q, cod_d;
    logic [NBITS-1:0]  txd_q, txd_d;
    logic              tx_start_q, tx_start_d;
    logic              error_q, error_d;
    logic              overrun_q, overrun_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [COD_OP-1:0] rx_low;
    logic              op_valid;
    logic              timeout_hit;

    // Opcode byte is legal only with clear upper bits and a known ALU code.
    always_comb begin
        rx_low   = rx_data[COD_OP-1:0];
        op_valid = ((rx_data >> COD_OP) == '0) &&
                   (rx_low inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                                   OP_XOR, OP_NOR, OP_SRA, OP_SRL});
    end

    // The counter restarts at 0 on entry to WAIT_B/WAIT_OP, so the edge on
    // which it would reach TIMEOUT is the one where it currently holds
    // TIMEOUT-1; the wait is abandoned on that edge.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    // Next-state and datapath decisions for the command sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        cod_d      = cod_q;
        txd_d      = txd_q;
        tx_start_d = 1'b0;
        error_d    = 1'b0;
        overrun_d  = 1'b0;
        cnt_d      = '0;

        case (state_q)
            S_WAIT_A: begin
                if (rx_done) begin
                    opa_d   = rx_data;
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                // A byte on the expiry edge wins over the timeout.
                if (rx_done) begin
                    opb_d   = rx_data;
                    state_d = S_WAIT_OP;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = S_WAIT_A;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_OP: begin
                if (rx_done) begin
                    if (op_valid) begin
                        cod_d   = rx_low;
                        state_d = S_EXEC;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_WAIT_A;
                    end
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = S_WAIT_A;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXEC: begin
                // Operands and opcode were registered last edge, so the ALU
                // output has settled by now.
                txd_d      = ALU_Result;
                tx_start_d = 1'b1;
                overrun_d  = rx_done;
                state_d    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                overrun_d = rx_done;
                if (tx_done) begin
                    state_d = S_WAIT_A;
                end
            end
            default: begin
                state_d = S_WAIT_A;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_WAIT_A;
            opa_q      <= '0;
            opb_q      <= '0;
            cod_q      <= '0;
            txd_q      <= '0;
            tx_start_q <= 1'b0;
            error_q    <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            cod_q      <= cod_d;
            txd_q      <= txd_d;
            tx_start_q <= tx_start_d;
            error_q    <= error_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
        end
    end

    assign operando_A    = opa_q;
    assign operando_B    = opb_q;
    assign cod_operacion = cod_q;
    assign tx_data       = txd_q;
    assign tx_start      = tx_start_q;
    assign error         = error_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q == S_EXEC) || (state_q == S_WAIT_TX);

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Testbench for alu_uart_ctrl: directed scenarios plus randomized command
// traffic. Every cycle is compared against a transaction-level reference
// model that tracks how many bytes of the current command are held.
module tb_alu_uart_ctrl;

    localparam int NBITS   = 8;
    localparam int COD_OP  = 6;
    localparam int TIMEOUT = 100;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_done;
    logic [NBITS-1:0]  rx_data;
    logic              tx_done;
    logic              tx_start;
    logic [NBITS-1:0]  tx_data;
    logic [NBITS-1:0]  operando_A;
    logic [NBITS-1:0]  operando_B;
    logic [COD_OP-1:0] cod_operacion;
    logic [NBITS-1:0]  ALU_Result;
    logic              busy;
    logic              error;
    logic              overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [7:0] m_a, m_b, m_tx;
    logic [5:0] m_op;
    int         m_have;
    int         m_quiet;
    bit         m_busy, m_fresh, m_err, m_ovr, m_start;

    logic [7:0] valid_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25,
                                  8'h26, 8'h27, 8'h03, 8'h02};

    always #5 clk = ~clk;

    alu_uart_ctrl #(
        .NBITS  (NBITS),
        .COD_OP (COD_OP),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done      (rx_done),
        .rx_data      (rx_data),
        .tx_done      (tx_done),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .operando_A   (operando_A),
        .operando_B   (operando_B),
        .cod_operacion(cod_operacion),
        .ALU_Result   (ALU_Result),
        .busy         (busy),
        .error        (error),
        .overrun      (overrun)
    );

    // Behavioural ALU: B is the shift amount for SRA/SRL.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb ALU_Result = alu_fn(operando_A, operando_B, cod_operacion);

    function automatic bit is_valid(input logic [7:0] b);
        logic [5:0] lo;
        lo = b[5:0];
        return (b[7:6] == 2'b00) &&
               (lo inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02});
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_tx = 0; m_op = 0;
        m_have = 0; m_quiet = 0;
        m_busy = 0; m_fresh = 0; m_err = 0; m_ovr = 0; m_start = 0;
    endtask

    // One clock edge of the command protocol, applied to the model.
    task automatic model_update(input bit rx, input logic [7:0] b, input bit txd);
        m_err = 0; m_ovr = 0; m_start = 0;
        if (m_busy) begin
            if (rx) m_ovr = 1;
            if (m_fresh) begin
                m_tx    = alu_fn(m_a, m_b, m_op);
                m_start = 1;
                m_fresh = 0;
            end else if (txd) begin
                m_busy = 0;
            end
        end else if (rx) begin
            m_quiet = 0;
            case (m_have)
                0: begin m_a = b; m_have = 1; end
                1: begin m_b = b; m_have = 2; end
                default: begin
                    if (is_valid(b)) begin
                        m_op = b[5:0]; m_busy = 1; m_fresh = 1;
                    end else begin
                        m_err = 1;
                    end
                    m_have = 0;
                end
            endcase
        end else if (m_have > 0) begin
            m_quiet++;
            if (m_quiet == TIMEOUT) begin
                m_err = 1; m_have = 0; m_quiet = 0;
            end
        end
    endtask

    task automatic check_all();
        check("operando_A",    32'(operando_A),    32'(m_a));
        check("operando_B",    32'(operando_B),    32'(m_b));
        check("cod_operacion", 32'(cod_operacion), 32'(m_op));
        check("tx_data",       32'(tx_data),       32'(m_tx));
        check("tx_start",      32'(tx_start),      32'(m_start));
        check("busy",          32'(busy),          32'(m_busy));
        check("error",         32'(error),         32'(m_err));
        check("overrun",       32'(overrun),       32'(m_ovr));
    endtask

    // Drive inputs for one edge, advance the model, compare 1 ns later.
    task automatic step(input bit rx, input logic [7:0] b, input bit txd);
        rx_done = rx; rx_data = b; tx_done = txd;
        @(posedge clk);
        model_update(rx, b, txd);
        #1;
        rx_done = 1'b0; tx_done = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp_res);
        step(1'b1, a, 1'b0);
        step(1'b1, b, 1'b0);
        step(1'b1, op, 1'b0);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_no_start", 32'(tx_start), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        check("result", 32'(tx_data), 32'(exp_res));
        check("start_pulse", 32'(tx_start), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("start_single", 32'(tx_start), 32'd0);
        idle(2);
        check("busy_wait_tx", 32'(busy), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("idle_after_tx", 32'(busy), 32'd0);
    endtask

    initial begin
        int hit_at;
        reset = 1'b1; rx_done = 1'b0; rx_data = '0; tx_done = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // Basic command and the other logic ops.
        run_cmd(8'h04, 8'h0C, 8'h20, 8'h10);
        check("opcode_add", 32'(cod_operacion), 32'h20);
        run_cmd(8'h04, 8'h0C, 8'h22, 8'hF8);
        run_cmd(8'h04, 8'h0C, 8'h24, 8'h04);
        run_cmd(8'h04, 8'h0C, 8'h25, 8'h0C);
        run_cmd(8'h04, 8'h0C, 8'h26, 8'h08);

        // Invalid opcode: error pulse, no transmission, opcode kept.
        step(1'b1, 8'h04, 1'b0);
        step(1'b1, 8'h0C, 1'b0);
        step(1'b1, 8'h3F, 1'b0);
        check("bad_op_error", 32'(error), 32'd1);
        check("bad_op_keep", 32'(cod_operacion), 32'h26);
        step(1'b0, 8'h00, 1'b0);
        check("bad_op_no_start", 32'(tx_start), 32'd0);
        run_cmd(8'h01, 8'h02, 8'h20, 8'h03);

        // Timeout after exactly TIMEOUT silent cycles in WAIT_B.
        step(1'b1, 8'h04, 1'b0);
        hit_at = 0;
        for (int k = 1; k <= 150; k++) begin
            step(1'b0, 8'h00, 1'b0);
            if (error) begin
                hit_at = k;
                break;
            end
        end
        check("timeout_cycles", 32'(hit_at), 32'd100);
        step(1'b1, 8'h77, 1'b0);
        check("after_timeout_A", 32'(operando_A), 32'h77);

        // Byte arriving on the expiry edge is accepted without error.
        idle(TIMEOUT - 1);
        step(1'b1, 8'h33, 1'b0);
        check("expiry_accept_B", 32'(operando_B), 32'h33);
        check("expiry_no_error", 32'(error), 32'd0);
        step(1'b1, 8'h25, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("expiry_result", 32'(tx_data), 32'h77);
        step(1'b0, 8'h00, 1'b1);

        // Overrun in EXEC, in WAIT_TX, and together with tx_done.
        step(1'b1, 8'h10, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        step(1'b1, 8'h66, 1'b0);
        check("ovr_exec", 32'(overrun), 32'd1);
        step(1'b1, 8'h55, 1'b0);
        check("ovr_wait_tx", 32'(overrun), 32'd1);
        check("ovr_keep_A", 32'(operando_A), 32'h10);
        step(1'b1, 8'h55, 1'b1);
        check("ovr_with_txdone", 32'(overrun), 32'd1);
        check("ovr_back_idle", 32'(busy), 32'd0);
        check("ovr_not_captured", 32'(operando_A), 32'h10);

        // Asynchronous reset after A and B.
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hBB, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        check("reset_opA", 32'(operando_A), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_cmd(8'h05, 8'h03, 8'h22, 8'h02);

        // Randomized traffic, including bad opcodes, timeouts and overruns.
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 3; j++) begin
                logic [7:0] byt;
                int gap;
                gap = $urandom_range(0, 4);
                if ($urandom_range(0, 19) == 0) gap = TIMEOUT + 5;
                idle(gap);
                if (j == 2 && $urandom_range(0, 3) != 0)
                    byt = valid_ops[$urandom_range(0, 7)];
                else
                    byt = 8'($urandom);
                step(1'b1, byt, 1'b0);
            end
            repeat ($urandom_range(1, 6))
                step($urandom_range(0, 3) == 0, 8'($urandom), 1'b0);
            step($urandom_range(0, 4) == 0, 8'($urandom), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
